// File: rtl/hazard_scoreboard.sv
// Hazard controller for the in-order pipeline: tracks in-flight destinations from EX
// through writeback and derives load-use stalls, flush control and operand forwarding.
module hazard_scoreboard #(
    parameter int XLEN       = 32,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [4:0]                 id_rs1,
    input  logic [4:0]                 id_rs2,
    input  logic [4:0]                 id_rd,
    input  logic                       id_use_rs1,
    input  logic                       id_use_rs2,
    input  logic                       id_regwen,
    input  logic                       id_is_load,
    input  logic                       ex_flush,
    input  logic [XLEN-1:0]            ex_rf_data1,
    input  logic [XLEN-1:0]            ex_rf_data2,
    input  logic [FWD_STAGES*XLEN-1:0] stg_data,
    output logic                       stall,
    output logic                       flush,
    output logic [2:0]                 fwd_a_sel,
    output logic [2:0]                 fwd_b_sel,
    output logic [XLEN-1:0]            ex_op_a,
    output logic [XLEN-1:0]            ex_op_b,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwen;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
    } sb_entry_t;

    // Entry 0 is EX; entry k is post-EX stage k.
    sb_entry_t        sb_r [0:FWD_STAGES];
    sb_entry_t        entry0_next_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             load_use_s;
    logic             stall_s;
    logic             flush_s;
    logic [2:0]       fwd_a_sel_s;
    logic [2:0]       fwd_b_sel_s;
    logic [XLEN-1:0]  op_a_s;
    logic [XLEN-1:0]  op_b_s;
    logic             unused_s;

    function automatic logic producer_match(sb_entry_t p, logic [4:0] src);
        return p.valid && p.regwen && (p.rd != 5'd0) && (p.rd == src);
    endfunction

    // A load still inside its latency window has no forwardable data yet.
    function automatic logic fwd_ok(sb_entry_t p, int k, logic [4:0] src);
        return producer_match(p, src) && !(p.is_load && (k <= LOAD_LAT));
    endfunction

    // Load-use detection against loads still short of their latency.
    always_comb begin
        load_use_s = 1'b0;
        for (int s = 0; s < LOAD_LAT; s++) begin
            if (sb_r[s].is_load &&
                ((id_use_rs1 && producer_match(sb_r[s], id_rs1)) ||
                 (id_use_rs2 && producer_match(sb_r[s], id_rs2)))) begin
                load_use_s = 1'b1;
            end else begin
                load_use_s = load_use_s;
            end
        end
        stall_s = rst && id_valid && !ex_flush && load_use_s;
        flush_s = rst && ex_flush;
    end

    // Forward select: walking oldest to youngest leaves the youngest match in place.
    always_comb begin
        fwd_a_sel_s = 3'd0;
        fwd_b_sel_s = 3'd0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (sb_r[0].use_rs1 && fwd_ok(sb_r[k], k, sb_r[0].rs1)) begin
                fwd_a_sel_s = 3'(k);
            end else begin
                fwd_a_sel_s = fwd_a_sel_s;
            end
            if (sb_r[0].use_rs2 && fwd_ok(sb_r[k], k, sb_r[0].rs2)) begin
                fwd_b_sel_s = 3'(k);
            end else begin
                fwd_b_sel_s = fwd_b_sel_s;
            end
        end
        if (!rst) begin
            fwd_a_sel_s = 3'd0;
            fwd_b_sel_s = 3'd0;
        end else begin
            fwd_a_sel_s = fwd_a_sel_s;
            fwd_b_sel_s = fwd_b_sel_s;
        end
    end

    // EX operand muxes.
    always_comb begin
        op_a_s = ex_rf_data1;
        op_b_s = ex_rf_data2;
        for (int k = 1; k <= FWD_STAGES; k++) begin
            if (fwd_a_sel_s == 3'(k)) begin
                op_a_s = stg_data[(k-1)*XLEN +: XLEN];
            end else begin
                op_a_s = op_a_s;
            end
            if (fwd_b_sel_s == 3'(k)) begin
                op_b_s = stg_data[(k-1)*XLEN +: XLEN];
            end else begin
                op_b_s = op_b_s;
            end
        end
    end

    // Next EX entry: the ID instruction, or a bubble on stall/flush/empty ID.
    always_comb begin
        entry0_next_s = '0;
        if (id_valid && !stall_s && !ex_flush) begin
            entry0_next_s.valid   = 1'b1;
            entry0_next_s.rd      = id_rd;
            entry0_next_s.regwen  = id_regwen;
            entry0_next_s.is_load = id_is_load;
            entry0_next_s.rs1     = id_rs1;
            entry0_next_s.rs2     = id_rs2;
            entry0_next_s.use_rs1 = id_use_rs1;
            entry0_next_s.use_rs2 = id_use_rs2;
        end else begin
            entry0_next_s = '0;
        end
    end

    // Scoreboard shift and saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k <= FWD_STAGES; k++) begin
                sb_r[k] <= '0;
            end
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            sb_r[0] <= entry0_next_s;
            for (int k = 1; k <= FWD_STAGES; k++) begin
                sb_r[k] <= sb_r[k-1];
            end
            if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
        end
    end

    // Fields carried for completeness but not consumed by every stage.
    always_comb begin
        unused_s = 1'b0;
        for (int k = 0; k <= FWD_STAGES; k++) begin
            unused_s = unused_s ^ (^sb_r[k]);
        end
    end

    assign stall     = stall_s;
    assign flush     = flush_s;
    assign fwd_a_sel = fwd_a_sel_s;
    assign fwd_b_sel = fwd_b_sel_s;
    assign ex_op_a   = op_a_s;
    assign ex_op_b   = op_b_s;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule
